div16_seq: RTL and testbench

DIV16_SEQ -- requirements
Module: div16_seq

---
 rtl/div16_seq.sv | 82 ++++++++
 tb/tb_div16_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/div16_seq.sv
// div16_seq: sequential restoring unsigned divider, one quotient bit per cycle
module div16_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op1_16,
   input  logic [WIDTH-1:0] op2_16,
   output logic [WIDTH-1:0] quot_16,
   output logic [WIDTH-1:0] rem_16,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;
   localparam logic [4:0] LAST = 5'(WIDTH - 1);

   logic [1:0]       state;
   logic [4:0]       cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH:0]   prem;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] sum;
   logic             borrow;
   logic             dsr_zero;

   // trial subtraction: shifted remainder plus two's complement of the divisor;
   // prem[WIDTH] is always 0 after a restore, used as the extension bit of the add
   always_comb begin
      shifted  = {prem[WIDTH-1:0], dvd[WIDTH-1]};
      sum      = {prem[WIDTH], shifted} + {1'b0, ~{1'b0, dsr}} + {{(WIDTH+1){1'b0}}, 1'b1};
      borrow   = ~sum[WIDTH+1];
      dsr_zero = dsr == '0;
   end

   // control FSM, iteration datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         dvd         <= '0;
         dsr         <= '0;
         prem        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quot_16     <= '0;
         rem_16      <= '0;
      end else begin
         done <= state == FIN;
         case (state)
            IDLE: if (start) begin
               dvd         <= op1_16;
               dsr         <= op2_16;
               prem        <= '0;
               cnt         <= '0;
               div_by_zero <= 1'b0;
               busy        <= op2_16 != '0;
               state       <= op2_16 != '0 ? RUN : FIN;
            end
            RUN: begin
               prem  <= borrow ? shifted : sum[WIDTH:0];
               dvd   <= {dvd[WIDTH-2:0], ~borrow};
               cnt   <= cnt == LAST ? cnt : cnt + 5'd1;
               state <= cnt == LAST ? FIN : RUN;
            end
            FIN: begin
               state       <= IDLE;
               busy        <= 1'b0;
               quot_16     <= dsr_zero ? '1 : dvd;
               rem_16      <= dsr_zero ? dvd : prem[WIDTH-1:0];
               div_by_zero <= dsr_zero;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div16_seq.sv
// tb_div16_seq: scoreboard bench for div16_seq with directed and random divisions
module tb_div16_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] op1_16 = '0;
   logic [15:0] op2_16 = '0;
   logic [15:0] quot_16;
   logic [15:0] rem_16;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   div16_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .op1_16(op1_16), .op2_16(op2_16),
      .quot_16(quot_16), .rem_16(rem_16), .busy(busy), .done(done),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        z;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int passed = 0;
   int dones  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // reference model: plain integer division, zero divisor gives all ones / dividend
   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      op1_16 = a;
      op2_16 = b;
      start  = 1'b1;
      @(posedge clk);
      #1;
      e.z   = b == 16'd0;
      e.q   = e.z ? 16'hFFFF : a / b;
      e.r   = e.z ? a : a % b;
      e.acc = cyc;
      exp_q.push_back(e);
      start = 1'b0;
   endtask

   task automatic wait_done(output int bc);
      bit seen = 0;
      bc = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (busy) bc++;
         seen = done;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   // monitor: every done pulse is matched against the oldest expected result
   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         dones++;
         chk("busy_with_done", {31'd0, busy}, 32'd0);
         if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            chk("quot", {16'd0, quot_16}, {16'd0, e.q});
            chk("rem", {16'd0, rem_16}, {16'd0, e.r});
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
            chk("latency", cyc - e.acc, e.z ? 32'd1 : 32'd17);
         end
      end
   end

   initial begin
      int bc;
      int d0;
      logic [15:0] a;
      logic [15:0] b;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      chk("rst_quot", {16'd0, quot_16}, 32'd0);
      chk("rst_rem", {16'd0, rem_16}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      issue(16'd100, 16'd7);
      wait_done(bc);
      chk("busy_len_100_7", bc, 32'd17);
      repeat (5) @(negedge clk);
      chk("hold_quot", {16'd0, quot_16}, 32'd14);
      chk("hold_rem", {16'd0, rem_16}, 32'd2);
      issue(16'd3, 16'd10);
      repeat (3) @(negedge clk);
      chk("prev_quot_while_busy", {16'd0, quot_16}, 32'd14);
      chk("prev_rem_while_busy", {16'd0, rem_16}, 32'd2);
      wait_done(bc);
      issue(16'hFFFF, 16'h0001);
      wait_done(bc);
      issue(16'hFFFF, 16'hFFFF);
      wait_done(bc);
      issue(16'd5, 16'd0);
      wait_done(bc);
      chk("busy_len_div0", bc, 32'd0);
      repeat (3) @(negedge clk);
      d0 = dones;
      issue(16'd100, 16'd7);
      repeat (4) @(negedge clk);
      op1_16 = 16'd50;
      op2_16 = 16'd5;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(bc);
      repeat (25) @(negedge clk);
      chk("single_done", dones - d0, 32'd1);
      issue(16'd1000, 16'd3);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_quot", {16'd0, quot_16}, 32'd0);
      chk("abort_rem", {16'd0, rem_16}, 32'd0);
      d0 = dones;
      repeat (25) @(negedge clk);
      chk("abort_no_done", dones - d0, 32'd0);
      issue(16'd1000, 16'd3);
      wait_done(bc);
      chk("busy_len_1000_3", bc, 32'd17);
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom);
         b = $urandom_range(0, 9) == 0 ? 16'd0 :
             $urandom_range(0, 1) == 0 ? 16'($urandom_range(1, 300)) : 16'($urandom);
         issue(a, b);
         wait_done(bc);
         chk("busy_len_rand", bc, b == 16'd0 ? 32'd0 : 32'd17);
      end
      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
